// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage running loads/stores over a req/ack data-memory port
//
// Purpose:
//   Sits between EX/MEM and MEM/WB. Non-memory instructions and misaligned
//   memory instructions pass straight through combinationally. An aligned
//   load/store stalls the upstream pipeline and sends bubbles to MEM/WB.
//   The access is issued on a registered req/ack port and waited on, with a
//   bounded wait. The held instruction is then released with its load data.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pc_4_m_i       PC+4 from EX/MEM
//   y_i            ALU result / memory byte address
//   b_i            store data
//   rdm_i          destination register
//   ctrlm_i        control word (MR_BIT = load, MW_BIT = store)
//   dmem_req       memory request (registered)
//   dmem_we        1 = write (registered)
//   dmem_addr      word-aligned address (registered)
//   dmem_wdata     write data (registered)
//   dmem_ack       one-cycle completion pulse
//   dmem_rdata     read data, valid with dmem_ack
//   pc_4_w_o       PC+4 to MEM/WB
//   ym_o           ALU result to MEM/WB
//   mdr_o          load data to MEM/WB
//   rdw_o          destination register to MEM/WB
//   ctrlw_o        control word to MEM/WB (0 = bubble)
//   stall_o        hold PC, IF/ID, ID/EX, EX/MEM
//   err_o          sticky error: misaligned access or timeout
module mem_access_stage #(
  parameter int MR_BIT  = 5,
  parameter int MW_BIT  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_4_m_i,
  input  logic [31:0] y_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  rdm_i,
  input  logic [31:0] ctrlm_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_4_w_o,
  output logic [31:0] ym_o,
  output logic [31:0] mdr_o,
  output logic [4:0]  rdw_o,
  output logic [31:0] ctrlw_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdr_q, mdr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic memop;
  logic mis;

  assign memop = ctrlm_i[MR_BIT] | ctrlm_i[MW_BIT];
  assign mis   = memop & (y_i[1:0] != 2'b00);

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (memop && !mis) begin
          addr_d  = {y_i[31:2], 2'b00};
          wdata_d = b_i;
          we_d    = ctrlm_i[MW_BIT];
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (mis) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // req_q is always 1 in WAIT, so ack is trusted here and ignored elsewhere.
        // The EX/MEM inputs are frozen by the stall, so ctrlm_i still describes
        // the outstanding access.
        if (dmem_ack) begin
          mdr_d   = ctrlm_i[MR_BIT] ? dmem_rdata : 32'd0;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mdr_d   = 32'd0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Unconditional return: the stall lifts here, so the next edge loads a
        // new instruction and the completed one is never re-issued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mdr_q   <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // MEM/WB outputs and stall
  always_comb begin
    pc_4_w_o = pc_4_m_i;
    ym_o     = y_i;
    rdw_o    = rdm_i;
    ctrlw_o  = ctrlm_i;
    mdr_o    = 32'd0;
    stall_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop && !mis) begin
          stall_o = 1'b1;
          ctrlw_o = 32'd0;
          rdw_o   = 5'd0;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        ctrlw_o = 32'd0;
        rdw_o   = 5'd0;
      end
      S_DONE: begin
        mdr_o = mdr_q;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign err_o      = err_q;

endmodule
